// File: rtl/avalon_mm_ram_agent_if.sv
// rtl/avalon_mm_ram_agent_if.sv - Avalon-MM host/agent bus bundle
interface avalon_mm_ram_agent_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_mm_ram_agent.sv
// rtl/avalon_mm_ram_agent.sv - Avalon-MM RAM agent with programmable wait states, read latency and pending limit
module avalon_mm_ram_agent #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_PENDING  = 2,
    parameter logic [31:0] BAD_DATA     = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_mm_ram_agent_if.slave bus,
    output logic                 bad_access
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    logic [31:0]             mem [DEPTH_WORDS];
    logic [AW-1:0]           idx;
    logic                    in_range;
    logic                    cmd;
    logic                    wait_stall;
    logic                    pend_full;
    logic                    acc;
    logic                    acc_rd;
    logic                    acc_wr;
    logic [3:0]              wcnt;
    logic [PW-1:0]           pending;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [31:0]             pipe_d [READ_LATENCY];
    logic [31:0]             rd_word;
    logic                    unused_addr_lsbs;

    // Byte address to word index; anything above the RAM window is out of range.
    assign idx              = bus.address[AW+1:2];
    assign in_range         = (bus.address[31:AW+2] == '0);
    assign unused_addr_lsbs = ^bus.address[1:0];

    assign cmd       = bus.read | bus.write;
    assign pend_full = (pending == PW'(MAX_PENDING));

    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign wait_stall = 1'b0;
        end else begin : g_wait
            assign wait_stall = (wcnt < 4'(WAIT_CYCLES));
        end
    endgenerate

    // Held high throughout reset so no command can slip in while state is cleared.
    assign bus.waitrequest = ~rst | (cmd & (wait_stall | (bus.read & pend_full)));

    assign acc    = cmd & ~bus.waitrequest;
    assign acc_rd = acc & bus.read;
    assign acc_wr = acc & bus.write;

    // RAM sampled combinationally so a read captures pre-write data at its acceptance edge.
    assign rd_word = in_range ? mem[idx] : BAD_DATA;

    // Wait counter: counts stalled command cycles, restarts on acceptance or a dropped command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 4'd0;
        end else if (!cmd || acc) begin
            wcnt <= 4'd0;
        end else if (wcnt != 4'hF) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Byte-lane RAM write; never reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (acc_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    mem[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    // Read return pipeline: data only advances with its valid so the last stage holds between returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_d[k] <= 32'd0;
            end
        end else begin
            pipe_v[0] <= acc_rd;
            if (acc_rd) begin
                pipe_d[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end
    end

    assign bus.readdatavalid = pipe_v[READ_LATENCY-1];
    assign bus.readdata      = pipe_d[READ_LATENCY-1];

    // Outstanding-read count: up on acceptance, down as each response is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            case ({acc_rd, bus.readdatavalid})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Sticky flag for any accepted command outside the RAM window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_access <= 1'b0;
        end else if (acc && !in_range) begin
            bad_access <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avalon_mm_ram_agent.sv
// tb/tb_avalon_mm_ram_agent.sv - directed and randomized checks for avalon_mm_ram_agent
module tb_avalon_mm_ram_agent;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic bad_a, bad_b, bad_c;
    int   checks = 0;
    int   errors = 0;

    avalon_mm_ram_agent_if bus_a ();
    avalon_mm_ram_agent_if bus_b ();
    avalon_mm_ram_agent_if bus_c ();

    avalon_mm_ram_agent #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .READ_LATENCY(1), .MAX_PENDING(1), .BAD_DATA(32'hDEADBEEF))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a), .bad_access(bad_a));
    avalon_mm_ram_agent #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(2), .BAD_DATA(32'hDEADBEEF))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b), .bad_access(bad_b));
    avalon_mm_ram_agent #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .READ_LATENCY(4), .MAX_PENDING(4), .BAD_DATA(32'hDEADBEEF))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c), .bad_access(bad_c));

    typedef struct {
        int          acc;
        logic [31:0] data;
    } rsp_t;

    task automatic a_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, output int waits);
        bus_a.read = rd; bus_a.write = wr; bus_a.address = addr; bus_a.byteenable = be; bus_a.writedata = data;
        waits = 0;
        #1;
        while (bus_a.waitrequest === 1'b1 && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        @(negedge clk);
        bus_a.read = 1'b0; bus_a.write = 1'b0;
    endtask

    task automatic b_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, output int waits);
        bus_b.read = rd; bus_b.write = wr; bus_b.address = addr; bus_b.byteenable = be; bus_b.writedata = data;
        waits = 0;
        #1;
        while (bus_b.waitrequest === 1'b1 && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        @(negedge clk);
        bus_b.read = 1'b0; bus_b.write = 1'b0;
    endtask

    task automatic c_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, output int waits);
        bus_c.read = rd; bus_c.write = wr; bus_c.address = addr; bus_c.byteenable = be; bus_c.writedata = data;
        waits = 0;
        #1;
        while (bus_c.waitrequest === 1'b1 && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        @(negedge clk);
        bus_c.read = 1'b0; bus_c.write = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.read = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (bus_a.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", bus_a.readdatavalid); end
        checks++; if (bus_a.readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", bus_a.readdata); end
        checks++; if (bad_a !== 1'b0) begin errors++; $display("FAIL reset_bad got %b want 0", bad_a); end
        checks++; if (bus_a.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait_a got %b want 1", bus_a.waitrequest); end
        checks++; if (bus_c.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait_c got %b want 1", bus_c.waitrequest); end
        @(negedge clk);
        bus_a.read = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        checks++; if (bus_a.waitrequest !== 1'b0) begin errors++; $display("FAIL idle_wait got %b want 0", bus_a.waitrequest); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int w;
        a_access(1'b0, 1'b1, 32'h10, 4'hF, 32'h12345678, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL wr_waits got %0d want 0", w); end
        a_access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL rd_waits got %0d want 0", w); end
        checks++; if (bus_a.readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", bus_a.readdatavalid); end
        checks++; if (bus_a.readdata !== 32'h12345678) begin errors++; $display("FAIL rd_data got %h want 12345678", bus_a.readdata); end
        @(negedge clk);
        checks++; if (bus_a.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_valid_single got %b want 0", bus_a.readdatavalid); end
    endtask

    task automatic test_byte_enables();
        int w;
        a_access(1'b0, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, w);
        a_access(1'b0, 1'b1, 32'h20, 4'b0101, 32'h11223344, w);
        a_access(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, w);
        checks++; if (bus_a.readdatavalid !== 1'b1 || bus_a.readdata !== 32'hAA22CC44) begin
            errors++; $display("FAIL byteen got %b/%h want 1/aa22cc44", bus_a.readdatavalid, bus_a.readdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_same_cmd();
        int w;
        a_access(1'b0, 1'b1, 32'h30, 4'hF, 32'h01020304, w);
        a_access(1'b1, 1'b1, 32'h30, 4'b1001, 32'h0A0B0C0D, w);
        checks++; if (bus_a.readdatavalid !== 1'b1 || bus_a.readdata !== 32'h01020304) begin
            errors++; $display("FAIL rw_old got %b/%h want 1/01020304", bus_a.readdatavalid, bus_a.readdata);
        end
        @(negedge clk);
        a_access(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, w);
        checks++; if (bus_a.readdata !== 32'h0A02030D) begin errors++; $display("FAIL rw_new got %h want 0a02030d", bus_a.readdata); end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int w;
        a_access(1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, w);
        checks++; if (bad_a !== 1'b0) begin errors++; $display("FAIL bad_before got %b want 0", bad_a); end
        a_access(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, w);
        checks++; if (bus_a.readdatavalid !== 1'b1 || bus_a.readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL oor_read got %b/%h want 1/deadbeef", bus_a.readdatavalid, bus_a.readdata);
        end
        checks++; if (bad_a !== 1'b1) begin errors++; $display("FAIL bad_set got %b want 1", bad_a); end
        @(negedge clk);
        a_access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h11111111, w);
        a_access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, w);
        checks++; if (bus_a.readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_write_alias got %h want cafef00d", bus_a.readdata); end
        @(negedge clk);
        a_access(1'b1, 1'b0, 32'h80000010, 4'h0, 32'h0, w);
        checks++; if (bus_a.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_high got %h want deadbeef", bus_a.readdata); end
        repeat (3) @(negedge clk);
        checks++; if (bad_a !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", bad_a); end
    endtask

    task automatic test_wait_states();
        logic exp;
        bus_c.read = 1'b1; bus_c.address = 32'h0;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp = (k < 3);
            checks++; if (bus_c.waitrequest !== exp) begin errors++; $display("FAIL wait_held[%0d] got %b want %b", k, bus_c.waitrequest, exp); end
            @(negedge clk);
        end
        bus_c.read = 1'b0;
        repeat (6) @(negedge clk);
        bus_c.read = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus_c.waitrequest !== 1'b1) begin errors++; $display("FAIL wait_pre_drop[%0d] got %b want 1", k, bus_c.waitrequest); end
            @(negedge clk);
        end
        bus_c.read = 1'b0;
        #1;
        checks++; if (bus_c.waitrequest !== 1'b0) begin errors++; $display("FAIL wait_dropped got %b want 0", bus_c.waitrequest); end
        @(negedge clk);
        bus_c.read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp = (k < 3);
            checks++; if (bus_c.waitrequest !== exp) begin errors++; $display("FAIL wait_restart[%0d] got %b want %b", k, bus_c.waitrequest, exp); end
            @(negedge clk);
        end
        bus_c.read = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_pipelining();
        int          w;
        logic [31:0] wd [3];
        logic        exp_wr [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        exp_rdv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int          exp_idx [8] = '{0, 0, 0, 0, 1, 0, 0, 2};
        logic [31:0] addrs [5]   = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
        for (int k = 0; k < 3; k++) begin
            wd[k] = $urandom;
            b_access(1'b0, 1'b1, 32'(k * 4), 4'hF, wd[k], w);
        end
        for (int t = 0; t < 8; t++) begin
            checks++; if (bus_b.readdatavalid !== exp_rdv[t]) begin errors++; $display("FAIL pipe_rdv[%0d] got %b want %b", t, bus_b.readdatavalid, exp_rdv[t]); end
            if (exp_rdv[t]) begin
                checks++; if (bus_b.readdata !== wd[exp_idx[t]]) begin errors++; $display("FAIL pipe_data[%0d] got %h want %h", t, bus_b.readdata, wd[exp_idx[t]]); end
            end
            if (t < 5) begin
                bus_b.read = 1'b1; bus_b.address = addrs[t];
                #1;
                checks++; if (bus_b.waitrequest !== exp_wr[t]) begin errors++; $display("FAIL pipe_wait[%0d] got %b want %b", t, bus_b.waitrequest, exp_wr[t]); end
            end else begin
                bus_b.read = 1'b0;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        localparam int LB = 3;
        logic [31:0] mem [64];
        rsp_t        q [$];
        rsp_t        r;
        logic        bad_m = 1'b0;
        logic        rd, wr, exp_rdv, exp_wr;
        logic [31:0] addr, data;
        logic [3:0]  be;
        int          w, pend;
        for (int k = 0; k < 64; k++) begin
            mem[k] = $urandom;
            b_access(1'b0, 1'b1, 32'(k * 4), 4'hF, mem[k], w);
            checks++; if (w !== 0) begin errors++; $display("FAIL rand_preload[%0d] waits %0d want 0", k, w); end
        end
        for (int i = 0; i < 400; i++) begin
            while (q.size() > 0 && q[0].acc + LB - 1 < i - 1) void'(q.pop_front());
            exp_rdv = (q.size() > 0 && q[0].acc + LB - 1 == i - 1);
            checks++; if (bus_b.readdatavalid !== exp_rdv) begin errors++; $display("FAIL rand_rdv[%0d] got %b want %b", i, bus_b.readdatavalid, exp_rdv); end
            if (exp_rdv) begin
                checks++; if (bus_b.readdata !== q[0].data) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, bus_b.readdata, q[0].data); end
            end
            checks++; if (bad_b !== bad_m) begin errors++; $display("FAIL rand_bad[%0d] got %b want %b", i, bad_b, bad_m); end
            pend = q.size();
            if (i < 390) begin
                rd = 1'($urandom_range(0, 1));
                wr = ($urandom_range(0, 2) == 0);
            end else begin
                rd = 1'b0; wr = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h100;
            else addr = 32'($urandom_range(0, 32'h13F));
            be = 4'($urandom_range(0, 15));
            data = $urandom;
            exp_wr = rd && (pend == 2);
            bus_b.read = rd; bus_b.write = wr; bus_b.address = addr; bus_b.byteenable = be; bus_b.writedata = data;
            #1;
            checks++; if (bus_b.waitrequest !== exp_wr) begin errors++; $display("FAIL rand_wait[%0d] got %b want %b", i, bus_b.waitrequest, exp_wr); end
            if ((rd || wr) && !exp_wr) begin
                if (addr >= 32'd256) bad_m = 1'b1;
                if (rd) begin
                    r.acc = i;
                    r.data = (addr < 32'd256) ? mem[addr[7:2]] : 32'hDEADBEEF;
                    q.push_back(r);
                end
                if (wr && addr < 32'd256) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
                end
            end
            @(negedge clk);
        end
        bus_b.read = 1'b0; bus_b.write = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int w, k;
        logic seen;
        c_access(1'b0, 1'b1, 32'h40, 4'hF, 32'h5A5A1234, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL mid_wr_waits got %0d want 3", w); end
        c_access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, w);
        @(negedge clk);
        rst_c = 1'b0;
        bus_c.read = 1'b1;
        #1;
        checks++; if (bus_c.waitrequest !== 1'b1) begin errors++; $display("FAIL mid_rst_wait got %b want 1", bus_c.waitrequest); end
        @(negedge clk);
        rst_c = 1'b1;
        bus_c.read = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (bus_c.readdatavalid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_discard got rdv %b want 0", seen); end
        c_access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL mid_rd_waits got %0d want 3", w); end
        k = 0;
        while (bus_c.readdatavalid !== 1'b1 && k < 10) begin
            @(negedge clk); k++;
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL mid_latency got %0d want 3", k); end
        checks++; if (bus_c.readdata !== 32'h5A5A1234) begin errors++; $display("FAIL mid_data got %h want 5a5a1234", bus_c.readdata); end
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.byteenable = '0; bus_a.writedata = '0;
        bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.byteenable = '0; bus_b.writedata = '0;
        bus_c.read = 1'b0; bus_c.write = 1'b0; bus_c.address = '0; bus_c.byteenable = '0; bus_c.writedata = '0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enables();
        test_read_write_same_cmd();
        test_out_of_range();
        test_wait_states();
        test_pipelining();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
